// File: rtl/uart_tx_fifo.sv
// UART transmit FIFO: queues CPU characters and drains them through simple_uart_send's busy handshake.
// Optional sticky overflow flag enabled by defining UART_TXFIFO_OVF_EN.
module uart_tx_fifo #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 4,
    parameter int BUSY_WAIT  = 4
) (
    input  logic                  clk_i_w,
    input  logic                  rst_i_w,
    input  logic                  en_i_w,
    input  logic                  wr_i_w,
    input  logic [DATA_W-1:0]     wdat_i_w,
    output logic [1:0]            sta_o_r,
    output logic [DEPTH_LOG2:0]   level_o_r,
    output logic                  send_o_r,
    output logic [DATA_W-1:0]     schar_o_r,
    input  logic                  busy_i_w,
    output logic                  ovf_o_r,
    input  logic                  ovf_clr_i_w
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = $clog2(BUSY_WAIT + 1);
    localparam logic [DEPTH_LOG2:0] FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(BUSY_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    state_t                state;
    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rp;
    logic [DEPTH_LOG2-1:0] wp;
    logic [CNT_W-1:0]      cnt;
    logic [DEPTH_LOG2:0]   level_nxt;
    logic                  full;
    logic                  empty;
    logic                  pop;
    logic                  push;

    assign full  = (level_o_r == FULL_LVL);
    assign empty = (level_o_r == '0);
    assign pop   = (state == IDLE) && en_i_w && !empty && !busy_i_w;
    // A full FIFO can still take a push when the same cycle frees a slot.
    assign push  = wr_i_w && (!full || pop);

    // Status is decoded purely from registers, so no input reaches it combinationally.
    assign sta_o_r = {empty && (state == IDLE), full};

    always_comb begin
        level_nxt = level_o_r;
        if (push && !pop) begin
            level_nxt = level_o_r + 1'b1;
        end else if (pop && !push) begin
            level_nxt = level_o_r - 1'b1;
        end
    end

    always_ff @(posedge clk_i_w) begin
        if (push) begin
            mem[wp] <= wdat_i_w;
        end
    end

    always_ff @(posedge clk_i_w) begin
        if (rst_i_w) begin
            state     <= IDLE;
            rp        <= '0;
            wp        <= '0;
            level_o_r <= '0;
            cnt       <= '0;
            send_o_r  <= 1'b0;
            schar_o_r <= '0;
        end else begin
            send_o_r  <= 1'b0;
            level_o_r <= level_nxt;
            if (push) begin
                wp <= wp + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (pop) begin
                        state     <= LOAD;
                        schar_o_r <= mem[rp];
                        rp        <= rp + 1'b1;
                        send_o_r  <= 1'b1;
                    end
                end
                LOAD: begin
                    state <= WAIT_ACK;
                    cnt   <= '0;
                end
                // A receiver that never raises busy is treated as having taken the char.
                WAIT_ACK: begin
                    if (busy_i_w) begin
                        state <= WAIT_DONE;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!busy_i_w) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef UART_TXFIFO_OVF_EN
    logic drop;
    assign drop = wr_i_w && !push;

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk_i_w) begin
        if (rst_i_w) begin
            ovf_o_r <= 1'b0;
        end else if (drop) begin
            ovf_o_r <= 1'b1;
        end else if (ovf_clr_i_w) begin
            ovf_o_r <= 1'b0;
        end
    end
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr_i_w;
    assign ovf_o_r        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected chars, a monitor checks every send strobe.
module tb_uart_tx_fifo;

`ifdef UART_TXFIFO_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic       clk_i_w;
    logic       rst_i_w;
    logic       en_i_w;
    logic       wr_i_w;
    logic [7:0] wdat_i_w;
    logic [1:0] sta_o_r;
    logic [4:0] level_o_r;
    logic       send_o_r;
    logic [7:0] schar_o_r;
    logic       busy_i_w;
    logic       ovf_o_r;
    logic       ovf_clr_i_w;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         strobes = 0;
    int         last_send = 0;
    bit         have_last = 0;
    bit         check_gap = 0;
    bit         model_on = 0;
    logic [7:0] exp_q[$];

    uart_tx_fifo dut (
        .clk_i_w    (clk_i_w),
        .rst_i_w    (rst_i_w),
        .en_i_w     (en_i_w),
        .wr_i_w     (wr_i_w),
        .wdat_i_w   (wdat_i_w),
        .sta_o_r    (sta_o_r),
        .level_o_r  (level_o_r),
        .send_o_r   (send_o_r),
        .schar_o_r  (schar_o_r),
        .busy_i_w   (busy_i_w),
        .ovf_o_r    (ovf_o_r),
        .ovf_clr_i_w(ovf_clr_i_w)
    );

    initial clk_i_w = 1'b0;
    always #5 clk_i_w = ~clk_i_w;

    always @(posedge clk_i_w) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // One cycle of push stimulus; inputs change 1 time unit after the rising edge.
    task automatic applyStimulus(input logic w, input logic [7:0] d);
        wr_i_w   = w;
        wdat_i_w = d;
        @(posedge clk_i_w);
        #1;
        wr_i_w = 1'b0;
    endtask

    task automatic doReset();
        rst_i_w = 1'b1;
        repeat (2) @(posedge clk_i_w);
        #1;
        rst_i_w = 1'b0;
    endtask

    // Receiver model: busy rises one cycle after a strobe and stays high for 10 cycles.
    initial begin
        busy_i_w = 1'b0;
        forever begin
            @(posedge clk_i_w);
            #1;
            if (model_on && send_o_r) begin
                @(posedge clk_i_w);
                #1;
                busy_i_w = 1'b1;
                repeat (10) @(posedge clk_i_w);
                #1;
                busy_i_w = 1'b0;
            end
        end
    end

    // Monitor: every strobe must match the oldest expected char.
    always @(negedge clk_i_w) begin
        if (send_o_r) begin
            strobes++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_strobe: got char 0x%0h expected no strobe", schar_o_r);
            end else begin
                automatic logic [7:0] e = exp_q.pop_front();
                if (schar_o_r !== e) begin
                    errors++;
                    $display("[TB] FAIL strobe_char: got 0x%0h expected 0x%0h", schar_o_r, e);
                end
            end
            checks++;
            if (busy_i_w !== 1'b0) begin
                errors++;
                $display("[TB] FAIL strobe_while_busy: got busy %0b expected 0", busy_i_w);
            end
            if (check_gap && have_last) begin
                checks++;
                if (cyc - last_send < 11) begin
                    errors++;
                    $display("[TB] FAIL strobe_gap: got %0d cycles expected >= 11", cyc - last_send);
                end
            end
            last_send = cyc;
            have_last = 1'b1;
        end
    end

    task automatic waitDrained(input string name, input int budget);
        int n;
        n = 0;
        while (!(sta_o_r == 2'b10 && busy_i_w == 1'b0) && n < budget) begin
            @(posedge clk_i_w);
            #1;
            n++;
        end
        checkOutput(name, int'(sta_o_r), 2);
    endtask

    initial begin
        rst_i_w     = 1'b0;
        en_i_w      = 1'b0;
        wr_i_w      = 1'b0;
        wdat_i_w    = 8'h00;
        ovf_clr_i_w = 1'b0;

        // 1: reset state
        doReset();
        checkOutput("rst_send", int'(send_o_r), 0);
        checkOutput("rst_level", int'(level_o_r), 0);
        checkOutput("rst_sta", int'(sta_o_r), 2);
        checkOutput("rst_ovf", int'(ovf_o_r), 0);

        // 2: single char, strobe one cycle after the push edge, then timeout
        en_i_w = 1'b1;
        exp_q.push_back(8'h41);
        applyStimulus(1'b1, 8'h41);
        checkOutput("t2_no_early_send", int'(send_o_r), 0);
        @(posedge clk_i_w);
        #1;
        checkOutput("t2_send_e1", int'(send_o_r), 1);
        checkOutput("t2_schar", int'(schar_o_r), 'h41);
        @(posedge clk_i_w);
        #1;
        checkOutput("t2_send_e2", int'(send_o_r), 0);
        repeat (10) @(posedge clk_i_w);
        #1;
        checkOutput("t2_sta_drained", int'(sta_o_r), 2);
        checkOutput("t2_level", int'(level_o_r), 0);

        // 3: overfill with drain disabled
        en_i_w = 1'b0;
        for (int i = 0; i < 17; i++) applyStimulus(1'b1, 8'(i));
        checkOutput("t3_level_full", int'(level_o_r), 16);
        checkOutput("t3_sta_full", int'(sta_o_r), 1);
        checkOutput("t3_ovf", int'(ovf_o_r), int'(OVF_EN));
        ovf_clr_i_w = 1'b1;
        @(posedge clk_i_w);
        #1;
        ovf_clr_i_w = 1'b0;
        checkOutput("t3_ovf_clr", int'(ovf_o_r), 0);
        ovf_clr_i_w = 1'b1;
        applyStimulus(1'b1, 8'hEE);
        ovf_clr_i_w = 1'b0;
        checkOutput("t3_set_wins", int'(ovf_o_r), int'(OVF_EN));
        checkOutput("t3_level_kept", int'(level_o_r), 16);
        ovf_clr_i_w = 1'b1;
        @(posedge clk_i_w);
        #1;
        ovf_clr_i_w = 1'b0;
        checkOutput("t3_ovf_clr2", int'(ovf_o_r), 0);

        // 5: push into a full FIFO in the same cycle as the pop
        for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
        exp_q.push_back(8'h99);
        en_i_w = 1'b1;
        applyStimulus(1'b1, 8'h99);
        checkOutput("t5_level", int'(level_o_r), 16);
        checkOutput("t5_ovf", int'(ovf_o_r), 0);
        checkOutput("t5_send", int'(send_o_r), 1);
        waitDrained("t5_drained", 600);
        checkOutput("t5_queue_empty", exp_q.size(), 0);

        // 4: three chars through the busy model
        en_i_w = 1'b0;
        doReset();
        model_on  = 1'b1;
        have_last = 1'b0;
        check_gap = 1'b1;
        strobes   = 0;
        exp_q.push_back(8'h31);
        exp_q.push_back(8'h32);
        exp_q.push_back(8'h33);
        applyStimulus(1'b1, 8'h31);
        applyStimulus(1'b1, 8'h32);
        applyStimulus(1'b1, 8'h33);
        checkOutput("t4_level", int'(level_o_r), 3);
        en_i_w = 1'b1;
        waitDrained("t4_drained", 300);
        checkOutput("t4_strobes", strobes, 3);
        check_gap = 1'b0;

        // 6: reset during WAIT_DONE with 5 chars still queued
        en_i_w = 1'b0;
        doReset();
        strobes = 0;
        exp_q.push_back(8'h51);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'(8'h51 + i));
        en_i_w = 1'b1;
        begin
            int n;
            n = 0;
            while (send_o_r !== 1'b1 && n < 20) begin
                @(posedge clk_i_w);
                #1;
                n++;
            end
        end
        checkOutput("t6_first_send", int'(send_o_r), 1);
        repeat (4) @(posedge clk_i_w);
        #1;
        checkOutput("t6_busy_high", int'(busy_i_w), 1);
        checkOutput("t6_level_before", int'(level_o_r), 5);
        rst_i_w = 1'b1;
        @(posedge clk_i_w);
        #1;
        rst_i_w = 1'b0;
        checkOutput("t6_level_after", int'(level_o_r), 0);
        checkOutput("t6_sta_after", int'(sta_o_r), 2);
        repeat (30) @(posedge clk_i_w);
        #1;
        checkOutput("t6_strobes", strobes, 1);
        checkOutput("t6_queue_empty", exp_q.size(), 0);
        model_on = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
